hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage miniRV core. It keeps a shadow copy of the destination register, write-enable and load flag for the instructions in EX, MEM and WB. From these it drives the decode-stage forwarding muxes (`rs1_hazard`/`rs2_hazard` plus data-source selects) and detects load-use hazards, inserting a one-cycle stall. On a taken branch or jump it flushes the two younger instructions. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_fwd_select.sv | 36 +++
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared forwarding codes and shadow slot type for the miniRV hazard controller
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_EX   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [1:0] FWD_WB   = 2'd3;

  typedef struct packed {
    logic [4:0] wr;
    logic       we;
  } slot_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// rtl/hazard_ctrl_fwd_select.sv - per-source forwarding select and load-use detect
module fwd_select
  import hazard_ctrl_pkg::*;
(
  input  slot_t      ex,
  input  logic       ex_load,
  input  slot_t      mem,
  input  slot_t      wb,
  input  logic       id_valid,
  input  logic       rs_used,
  input  logic [4:0] rr,
  output logic [1:0] sel,
  output logic       load_use
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign src_live = id_valid && rs_used && (rr != 5'd0);
  assign ex_hit   = src_live && ex.we  && (ex.wr  == rr);
  assign mem_hit  = src_live && mem.we && (mem.wr == rr);
  assign wb_hit   = src_live && wb.we  && (wb.wr  == rr);
  assign load_use = ex_hit && ex_load;

  always_comb begin
    sel = FWD_NONE;
    // A load still in EX has no usable value, so it masks older matches.
    if (ex_hit && !ex_load) sel = FWD_EX;
    else if (ex_hit)        sel = FWD_NONE;
    else if (mem_hit)       sel = FWD_MEM;
    else if (wb_hit)        sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - miniRV hazard controller: forwarding, load-use stall, branch flush, event counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rR1,
  input  logic [4:0]       id_rR2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_wR,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             rs1_hazard,
  output logic             rs2_hazard,
  output logic [1:0]       rs1_fwd_sel,
  output logic [1:0]       rs2_fwd_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t ex_q, mem_q, wb_q;
  logic  ex_load_q;
  logic  lu1, lu2, lu;

  fwd_select u_fwd_rs1 (
    .ex       (ex_q),
    .ex_load  (ex_load_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .id_valid (id_valid),
    .rs_used  (id_rs1_used),
    .rr       (id_rR1),
    .sel      (rs1_fwd_sel),
    .load_use (lu1)
  );

  fwd_select u_fwd_rs2 (
    .ex       (ex_q),
    .ex_load  (ex_load_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .id_valid (id_valid),
    .rs_used  (id_rs2_used),
    .rr       (id_rR2),
    .sel      (rs2_fwd_sel),
    .load_use (lu2)
  );

  assign lu          = lu1 || lu2;
  assign rs1_hazard  = (rs1_fwd_sel != FWD_NONE);
  assign rs2_hazard  = (rs2_fwd_sel != FWD_NONE);
  // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
  assign pc_stall    = lu && !ex_branch_taken;
  assign if_id_stall = lu && !ex_branch_taken;
  assign if_id_flush = ex_branch_taken;
  assign id_ex_flush = ex_branch_taken || lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ex_load_q <= 1'b0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (id_ex_flush) begin
        ex_q      <= '0;
        ex_load_q <= 1'b0;
      end else begin
        ex_q.wr   <= id_wR;
        ex_q.we   <= id_rf_we && id_valid;
        ex_load_q <= id_is_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (ex_branch_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rR1, id_rR2, id_wR;
  logic        id_rs1_used, id_rs2_used, id_rf_we, id_is_load;
  logic        ex_branch_taken;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic        rs1_hazard, rs2_hazard;
  logic [1:0]  rs1_fwd_sel, rs2_fwd_sel;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_flush;
  logic        s_rs1_hazard, s_rs2_hazard;
  logic [1:0]  s_rs1_fwd_sel, s_rs2_fwd_sel;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rR1(id_rR1), .id_rR2(id_rR2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wR(id_wR),
    .id_rf_we(id_rf_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
    .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rR1(id_rR1), .id_rR2(id_rR2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wR(id_wR),
    .id_rf_we(id_rf_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .rs1_hazard(s_rs1_hazard), .rs2_hazard(s_rs2_hazard),
    .rs1_fwd_sel(s_rs1_fwd_sel), .rs2_fwd_sel(s_rs2_fwd_sel),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] wr, input logic we, input logic ld);
    id_valid = v; id_rR1 = r1; id_rs1_used = u1; id_rR2 = r2; id_rs2_used = u2;
    id_wR = wr; id_rf_we = we; id_is_load = ld;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_branch_taken = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_branch_taken = 0;
    rst = 1;
    tick();
    total++;
    if ({pc_stall, if_id_stall, if_id_flush, id_ex_flush, rs1_hazard, rs2_hazard,
         rs1_fwd_sel, rs2_fwd_sel} !== 10'b0)
      $display("FAIL reset_outputs: got %b want 0", {pc_stall, if_id_stall, if_id_flush,
               id_ex_flush, rs1_hazard, rs2_hazard, rs1_fwd_sel, rs2_fwd_sel});
    else passed++;
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    else passed++;
    rst = 0;
    // Consumer of a register right after reset must see no hazard.
    set_id(1, 5, 1, 6, 1, 7, 1, 0);
    #1;
    total++;
    if ({rs1_hazard, rs2_hazard, pc_stall} !== 3'b000)
      $display("FAIL reset_no_match: got %b want 000", {rs1_hazard, rs2_hazard, pc_stall});
    else passed++;
  endtask

  task automatic test_ex_fwd();
    do_reset();
    set_id(1, 1, 1, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 1, 6, 1, 0);
    #1;
    total++;
    if (rs1_fwd_sel !== 2'd1 || rs1_hazard !== 1'b1 || rs2_fwd_sel !== 2'd0)
      $display("FAIL ex_fwd: got sel1=%0d hz1=%0d sel2=%0d want 1 1 0",
               rs1_fwd_sel, rs1_hazard, rs2_fwd_sel);
    else passed++;
    total++;
    if (pc_stall !== 1'b0 || id_ex_flush !== 1'b0)
      $display("FAIL ex_fwd_nostall: got %b%b want 00", pc_stall, id_ex_flush);
    else passed++;
    tick();
  endtask

  task automatic test_gap_fwd();
    logic [1:0] want [4];
    want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
    for (int gap = 1; gap <= 3; gap++) begin
      do_reset();
      set_id(1, 1, 1, 0, 0, 5, 1, 0);
      tick();
      for (int g = 0; g < gap; g++) begin
        set_id(1, 1, 1, 2, 1, 9, 1, 0);
        tick();
      end
      set_id(1, 3, 1, 5, 1, 6, 1, 0);
      #1;
      total++;
      if (rs2_fwd_sel !== want[gap] || rs2_hazard !== (want[gap] != 2'd0) || rs1_fwd_sel !== 2'd0)
        $display("FAIL gap_fwd gap=%0d: got sel2=%0d hz2=%0d sel1=%0d want sel2=%0d sel1=0",
                 gap, rs2_fwd_sel, rs2_hazard, rs1_fwd_sel, want[gap]);
      else passed++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 2, 1, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 1, 7, 1, 8, 1, 0);
    #1;
    total++;
    if ({pc_stall, if_id_stall, if_id_flush, id_ex_flush} !== 4'b1101 ||
        rs1_fwd_sel !== 2'd0 || rs2_fwd_sel !== 2'd0)
      $display("FAIL load_use_stall: got ctl=%b sel=%0d/%0d want 1101 0/0",
               {pc_stall, if_id_stall, if_id_flush, id_ex_flush}, rs1_fwd_sel, rs2_fwd_sel);
    else passed++;
    tick();
    total++;
    if (pc_stall !== 1'b0 || id_ex_flush !== 1'b0 || rs1_fwd_sel !== 2'd2 || rs2_fwd_sel !== 2'd2)
      $display("FAIL load_use_after: got stall=%0d flush=%0d sel=%0d/%0d want 0 0 2/2",
               pc_stall, id_ex_flush, rs1_fwd_sel, rs2_fwd_sel);
    else passed++;
    total++;
    if (stall_cnt !== 32'd1)
      $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    else passed++;
    tick();
  endtask

  task automatic test_mixed();
    do_reset();
    set_id(1, 1, 1, 0, 0, 4, 1, 0);
    tick();
    set_id(1, 1, 1, 0, 0, 9, 1, 0);
    tick();
    set_id(1, 2, 1, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 1, 4, 1, 8, 1, 0);
    #1;
    total++;
    if (pc_stall !== 1'b1 || rs1_fwd_sel !== 2'd0 || rs2_fwd_sel !== 2'd3)
      $display("FAIL mixed_stall: got stall=%0d sel=%0d/%0d want 1 0/3",
               pc_stall, rs1_fwd_sel, rs2_fwd_sel);
    else passed++;
    tick();
    total++;
    if (pc_stall !== 1'b0 || rs1_fwd_sel !== 2'd2 || rs2_fwd_sel !== 2'd0)
      $display("FAIL mixed_after: got stall=%0d sel=%0d/%0d want 0 2/0",
               pc_stall, rs1_fwd_sel, rs2_fwd_sel);
    else passed++;
    tick();
    total++;
    if (stall_cnt !== 32'd1)
      $display("FAIL mixed_cnt: got %0d want 1", stall_cnt);
    else passed++;
  endtask

  task automatic test_lu_branch();
    do_reset();
    set_id(1, 2, 1, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 1, 7, 1, 8, 1, 0);
    ex_branch_taken = 1;
    #1;
    total++;
    if ({pc_stall, if_id_stall, if_id_flush, id_ex_flush} !== 4'b0011)
      $display("FAIL lu_branch_ctl: got %b want 0011",
               {pc_stall, if_id_stall, if_id_flush, id_ex_flush});
    else passed++;
    tick();
    ex_branch_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0)
      $display("FAIL lu_branch_cnt: got flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
    else passed++;
  endtask

  task automatic test_x0();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(1, 1, 1, 2, 1, 0, 1, (i == 2));
      tick();
    end
    set_id(1, 0, 1, 0, 1, 3, 1, 0);
    #1;
    total++;
    if ({rs1_hazard, rs2_hazard, rs1_fwd_sel, rs2_fwd_sel, pc_stall} !== 7'b0)
      $display("FAIL x0_no_hazard: got %b want 0",
               {rs1_hazard, rs2_hazard, rs1_fwd_sel, rs2_fwd_sel, pc_stall});
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
    set_id(1, 1, 1, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 1, 1, 0, 0, 6, 1, 0);
    tick();
    set_id(1, 1, 1, 0, 0, 7, 1, 0);
    tick();
    set_id(1, 7, 1, 6, 1, 8, 1, 0);
    #1;
    total++;
    if (rs1_fwd_sel !== 2'd1 || rs2_fwd_sel !== 2'd2 || flush_cnt !== 32'd1)
      $display("FAIL async_pre: got sel=%0d/%0d flush=%0d want 1/2 1",
               rs1_fwd_sel, rs2_fwd_sel, flush_cnt);
    else passed++;
    #2;
    rst = 1;
    #1;
    total++;
    if ({rs1_hazard, rs2_hazard, rs1_fwd_sel, rs2_fwd_sel} !== 6'b0 ||
        flush_cnt !== 32'd0 || stall_cnt !== 32'd0)
      $display("FAIL async_rst: got hz=%b%b sel=%0d/%0d flush=%0d stall=%0d want all 0",
               rs1_hazard, rs2_hazard, rs1_fwd_sel, rs2_fwd_sel, flush_cnt, stall_cnt);
    else passed++;
    tick();
    rst = 0;
    set_id(1, 1, 1, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    total++;
    if (rs1_fwd_sel !== 2'd1 || rs1_hazard !== 1'b1)
      $display("FAIL async_post: got sel=%0d hz=%0d want 1 1", rs1_fwd_sel, rs1_hazard);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    // Chain of dependent loads: every other cycle is a load-use stall.
    set_id(1, 7, 1, 0, 0, 7, 1, 1);
    repeat (40) tick();
    total++;
    if (stall_cnt !== 32'd20)
      $display("FAIL sat_wide_cnt: got %0d want 20", stall_cnt);
    else passed++;
    total++;
    if (s_stall_cnt !== 4'd15)
      $display("FAIL sat_narrow_cnt: got %0d want 15", s_stall_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_gap_fwd();
    test_load_use();
    test_mixed();
    test_lu_branch();
    test_x0();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
